// File: rtl/btb_pkg.sv
// Shared widths, the BTB update-queue entry type and an address-alignment helper
// for the BTB update controller slice.
package btb_pkg;

   localparam int BTB_PC_W  = 16;
   localparam int BTB_DEPTH = 4;

   typedef struct packed {
      logic [BTB_PC_W-1:0] pc;
      logic [BTB_PC_W-1:0] npc;
   } btb_upd_t;

   // BTB entries are word aligned, so the two byte-offset bits are never stored
   function automatic logic [BTB_PC_W-1:0] word_align(input logic [BTB_PC_W-1:0] addr);
      return addr & ~BTB_PC_W'(3);
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending BTB update queue: FIFO of {pc, npc} entries with wrap-bit pointers and a
// port that rewrites the target of the youngest entry in place.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = BTB_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                ovr,
   input  logic [BTB_PC_W-1:0] wr_pc,
   input  logic [BTB_PC_W-1:0] wr_npc,
   output logic                full,
   output logic                empty,
   output logic                one_left,
   output logic [BTB_PC_W-1:0] head_pc,
   output logic [BTB_PC_W-1:0] head_npc,
   output logic [BTB_PC_W-1:0] tail_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   btb_upd_t        mem [DEPTH];
   btb_upd_t        head_entry;
   btb_upd_t        tail_entry;
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [AW:0]     used;
   logic [AW-1:0]   tail_idx;

   // Equal index with differing wrap bits means the writer is a full lap ahead
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign used     = wr_ptr - rd_ptr;
   assign one_left = (used == (AW+1)'(1));
   assign tail_idx = wr_ptr[AW-1:0] - 1'b1;

   assign head_entry = mem[rd_ptr[AW-1:0]];
   assign tail_entry = mem[tail_idx];
   assign head_pc    = head_entry.pc;
   assign head_npc   = head_entry.npc;
   assign tail_pc    = tail_entry.pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is deliberately unreset; the pointers alone decide what is visible
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]].pc  <= wr_pc;
         mem[wr_ptr[AW-1:0]].npc <= wr_npc;
      end else if (ovr) begin
         mem[tail_idx].npc <= wr_npc;
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// EX-stage BTB update controller: flags mispredicts, redirects fetch, queues and
// drains BTB writes. Define BTB_UPD_MERGE_EN to merge repeat updates into the tail.
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int DEPTH = BTB_DEPTH,
   parameter int PC_W  = BTB_PC_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [PC_W-1:0] ex_PC,
   input  logic [PC_W-1:0] ex_NPC_actual,
   input  logic [PC_W-1:0] ex_NPC_predict,
   input  logic            btb_hold,
   output logic            redirect,
   output logic [PC_W-1:0] redirect_PC,
   output logic            we,
   output logic [PC_W-1:0] PC_actual,
   output logic [PC_W-1:0] NPC_actual,
   output logic [15:0]     mispredict_cnt,
   output logic [15:0]     drop_cnt
);

`ifdef BTB_UPD_MERGE_EN
   localparam logic MERGE_EN = 1'b1;
`else
   localparam logic MERGE_EN = 1'b0;
`endif

   logic            mispredict;
   logic            pop;
   logic            merge;
   logic            push;
   logic            drop;
   logic            full;
   logic            empty;
   logic            one_left;
   logic [PC_W-1:0] enq_pc;
   logic [PC_W-1:0] enq_npc;
   logic [PC_W-1:0] head_pc;
   logic [PC_W-1:0] head_npc;
   logic [PC_W-1:0] tail_pc;

   assign mispredict = ex_valid & ex_is_branch & (ex_NPC_actual != ex_NPC_predict);
   assign enq_pc     = word_align(ex_PC);
   assign enq_npc    = word_align(ex_NPC_actual);
   assign pop        = ~empty & ~btb_hold;

   // A tail that is also the head being popped this cycle cannot be merged into
   assign merge = MERGE_EN & mispredict & ~empty & (tail_pc == enq_pc) & ~(pop & one_left);
   assign push  = mispredict & ~merge & (~full | pop);
   assign drop  = mispredict & ~merge & full & ~pop;

   btb_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .ovr      (merge),
      .wr_pc    (enq_pc),
      .wr_npc   (enq_npc),
      .full     (full),
      .empty    (empty),
      .one_left (one_left),
      .head_pc  (head_pc),
      .head_npc (head_npc),
      .tail_pc  (tail_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect    <= 1'b0;
         redirect_PC <= '0;
         we          <= 1'b0;
         PC_actual   <= '0;
         NPC_actual  <= '0;
      end else begin
         redirect <= mispredict;
         if (mispredict) redirect_PC <= ex_NPC_actual;
         we <= pop;
         if (pop) begin
            PC_actual  <= head_pc;
            NPC_actual <= head_npc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_cnt <= '0;
         drop_cnt       <= '0;
      end else begin
         if (mispredict && (mispredict_cnt != 16'hFFFF)) mispredict_cnt <= mispredict_cnt + 16'd1;
         if (drop && (drop_cnt != 16'hFFFF))             drop_cnt       <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_btb_update_ctrl;
   import btb_pkg::*;

   localparam int DEPTH = 4;
   localparam int PC_W  = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ex_valid = 1'b0;
   logic            ex_is_branch = 1'b0;
   logic [PC_W-1:0] ex_PC = '0;
   logic [PC_W-1:0] ex_NPC_actual = '0;
   logic [PC_W-1:0] ex_NPC_predict = '0;
   logic            btb_hold = 1'b0;
   logic            redirect;
   logic [PC_W-1:0] redirect_PC;
   logic            we;
   logic [PC_W-1:0] PC_actual;
   logic [PC_W-1:0] NPC_actual;
   logic [15:0]     mispredict_cnt;
   logic [15:0]     drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   btb_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_PC          (ex_PC),
      .ex_NPC_actual  (ex_NPC_actual),
      .ex_NPC_predict (ex_NPC_predict),
      .btb_hold       (btb_hold),
      .redirect       (redirect),
      .redirect_PC    (redirect_PC),
      .we             (we),
      .PC_actual      (PC_actual),
      .NPC_actual     (NPC_actual),
      .mispredict_cnt (mispredict_cnt),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: pending updates as a plain list, outputs derived per edge
   logic [15:0] qpc[$];
   logic [15:0] qnpc[$];
   logic        m_red, m_we, mp, popping, merged, accept;
   logic [15:0] m_rpc, m_pc, m_npc, m_mc, m_dc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qpc.delete();
         qnpc.delete();
         m_red = 1'b0; m_rpc = '0; m_we = 1'b0; m_pc = '0; m_npc = '0; m_mc = '0; m_dc = '0;
      end else begin
         mp      = ex_valid && ex_is_branch && (ex_NPC_actual != ex_NPC_predict);
         popping = (qpc.size() != 0) && !btb_hold;
         merged  = 1'b0;
         m_red   = mp;
         if (mp) m_rpc = ex_NPC_actual;
         m_we = popping;
         if (popping) begin
            m_pc  = qpc[0];
            m_npc = qnpc[0];
         end
`ifdef BTB_UPD_MERGE_EN
         if (mp && qpc.size() != 0 && qpc[qpc.size()-1] == (ex_PC & 16'hFFFC)
             && !(popping && qpc.size() == 1)) begin
            qnpc[qnpc.size()-1] = ex_NPC_actual & 16'hFFFC;
            merged = 1'b1;
         end
`endif
         accept = mp && !merged && (qpc.size() < DEPTH || popping);
         if (popping) begin
            void'(qpc.pop_front());
            void'(qnpc.pop_front());
         end
         if (accept) begin
            qpc.push_back(ex_PC & 16'hFFFC);
            qnpc.push_back(ex_NPC_actual & 16'hFFFC);
         end
         if (mp && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
         if (mp && !merged && !accept && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         checkOutput("model.redirect",    32'(redirect),       32'(m_red));
         checkOutput("model.redirect_PC", 32'(redirect_PC),    32'(m_rpc));
         checkOutput("model.we",          32'(we),             32'(m_we));
         checkOutput("model.PC_actual",   32'(PC_actual),      32'(m_pc));
         checkOutput("model.NPC_actual",  32'(NPC_actual),     32'(m_npc));
         checkOutput("model.mispredict",  32'(mispredict_cnt), 32'(m_mc));
         checkOutput("model.drop",        32'(drop_cnt),       32'(m_dc));
      end
   end

   task automatic applyStimulus(input logic v, input logic br, input logic [15:0] pc,
                                input logic [15:0] act, input logic [15:0] pred, input logic hold);
      @(negedge clk);
      ex_valid = v; ex_is_branch = br; ex_PC = pc;
      ex_NPC_actual = act; ex_NPC_predict = pred; btb_hold = hold;
   endtask

   task automatic idle(input logic hold);
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, hold);
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      ex_valid = 1'b0; ex_is_branch = 1'b0; btb_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : main
      int pulses;
      logic [15:0] first_npc;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.redirect", 32'(redirect), 32'h0);
      checkOutput("reset.we", 32'(we), 32'h0);
      checkOutput("reset.PC_actual", 32'(PC_actual), 32'h0);
      checkOutput("reset.mispredict_cnt", 32'(mispredict_cnt), 32'h0);
      checkOutput("reset.drop_cnt", 32'(drop_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Correct prediction, non-branch and invalid instructions do nothing
      applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0104, 16'h0104, 1'b0);
      afterEdge();
      checkOutput("correct.redirect", 32'(redirect), 32'h0);
      applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0200, 16'h0104, 1'b0);
      afterEdge();
      checkOutput("nonbranch.redirect", 32'(redirect), 32'h0);
      applyStimulus(1'b0, 1'b1, 16'h0100, 16'h0200, 16'h0104, 1'b0);
      afterEdge();
      checkOutput("invalid.we", 32'(we), 32'h0);
      checkOutput("correct.mispredict_cnt", 32'(mispredict_cnt), 32'h0);

      // Single mispredict: redirect next edge, BTB write one edge later
      applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0200, 16'h0104, 1'b0);
      afterEdge();
      checkOutput("mp.redirect", 32'(redirect), 32'h1);
      checkOutput("mp.redirect_PC", 32'(redirect_PC), 32'h0200);
      checkOutput("mp.cnt", 32'(mispredict_cnt), 32'h1);
      checkOutput("mp.we_early", 32'(we), 32'h0);
      idle(1'b0);
      afterEdge();
      checkOutput("mp.redirect_pulse", 32'(redirect), 32'h0);
      checkOutput("mp.we", 32'(we), 32'h1);
      checkOutput("mp.PC_actual", 32'(PC_actual), 32'h0100);
      checkOutput("mp.NPC_actual", 32'(NPC_actual), 32'h0200);
      idle(1'b0);
      afterEdge();
      checkOutput("mp.we_single", 32'(we), 32'h0);
      checkOutput("mp.PC_hold", 32'(PC_actual), 32'h0100);

      // Low address bits are cleared in stored entries but not in the redirect
      applyStimulus(1'b1, 1'b1, 16'h0123, 16'h0457, 16'h0127, 1'b0);
      afterEdge();
      checkOutput("align.redirect_PC", 32'(redirect_PC), 32'h0457);
      idle(1'b0);
      afterEdge();
      checkOutput("align.PC_actual", 32'(PC_actual), 32'h0120);
      checkOutput("align.NPC_actual", 32'(NPC_actual), 32'h0454);

      // Hold with five mispredicts: four queued, one dropped, then in-order drain
      doReset();
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b1, 16'(16'h1000 + 4*i), 16'(16'h2000 + 4*i), 16'h0000, 1'b1);
      idle(1'b1);
      afterEdge();
      checkOutput("hold.drop_cnt", 32'(drop_cnt), 32'h1);
      checkOutput("hold.mispredict_cnt", 32'(mispredict_cnt), 32'h5);
      checkOutput("hold.we", 32'(we), 32'h0);
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         afterEdge();
         checkOutput("drain.we", 32'(we), 32'h1);
         checkOutput("drain.PC_actual", 32'(PC_actual), 32'(16'h1000 + 4*i));
         checkOutput("drain.NPC_actual", 32'(NPC_actual), 32'(16'h2000 + 4*i));
      end
      idle(1'b0);
      afterEdge();
      checkOutput("drain.done", 32'(we), 32'h0);

      // Full queue, drain and push in the same cycle
      doReset();
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b1, 16'(16'h3000 + 4*i), 16'(16'h3800 + 4*i), 16'h0000, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'h4000, 16'h4800, 16'h0000, 1'b0);
      afterEdge();
      checkOutput("fullpush.drop_cnt", 32'(drop_cnt), 32'h0);
      checkOutput("fullpush.PC_actual", 32'(PC_actual), 32'h3000);
      for (int i = 1; i < 5; i++) begin
         idle(1'b0);
         afterEdge();
         checkOutput("fullpush.we", 32'(we), 32'h1);
         checkOutput("fullpush.PC_actual", 32'(PC_actual), (i < 4) ? 32'(16'h3000 + 4*i) : 32'h4000);
      end

      // Repeat mispredicts at one PC while held
      doReset();
      applyStimulus(1'b1, 1'b1, 16'h0300, 16'h0400, 16'h0304, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'h0300, 16'h0500, 16'h0304, 1'b1);
      pulses = 0;
      first_npc = '0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         afterEdge();
         if (we) begin
            if (pulses == 0) first_npc = NPC_actual;
            pulses++;
         end
      end
`ifdef BTB_UPD_MERGE_EN
      checkOutput("merge.pulses", 32'(pulses), 32'd1);
      checkOutput("merge.first_npc", 32'(first_npc), 32'h0500);
`else
      checkOutput("merge.pulses", 32'(pulses), 32'd2);
      checkOutput("merge.first_npc", 32'(first_npc), 32'h0400);
`endif

      // Reset in the middle of draining three entries
      doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 16'(16'h5000 + 4*i), 16'(16'h5800 + 4*i), 16'h0000, 1'b1);
      idle(1'b0);
      afterEdge();
      checkOutput("rstdrain.we_before", 32'(we), 32'h1);
      checkOutput("rstdrain.PC_before", 32'(PC_actual), 32'h5000);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstdrain.we", 32'(we), 32'h0);
      checkOutput("rstdrain.PC_actual", 32'(PC_actual), 32'h0);
      checkOutput("rstdrain.mispredict_cnt", 32'(mispredict_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      btb_hold = 1'b0;
      ex_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         afterEdge();
         if (we) pulses++;
      end
      checkOutput("rstdrain.no_writes", 32'(pulses), 32'd0);

      // Mispredict counter saturation
      doReset();
      for (int i = 0; i < 65540; i++)
         applyStimulus(1'b1, 1'b1, 16'(i*4), 16'(i*4 + 8), 16'(i*4 + 4), 1'b0);
      idle(1'b0);
      afterEdge();
      checkOutput("sat.mispredict_cnt", 32'(mispredict_cnt), 32'hFFFF);
      checkOutput("sat.drop_cnt", 32'(drop_cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, update-queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter PC_W, default 16, byte-address PC width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-006 SHALL have port ex_is_branch  input  1  EX instruction is a branch or jump.
REQ-007 SHALL have port ex_PC  input  PC_W  PC of EX instruction.
REQ-008 SHALL have port ex_NPC_actual  input  PC_W  resolved next PC.
REQ-009 SHALL have port ex_NPC_predict  input  PC_W  next PC predicted at fetch.
REQ-010 SHALL have port btb_hold  input  1  inhibits queue drain this cycle.
REQ-011 SHALL have port redirect  output  1  registered fetch redirect/flush pulse.
REQ-012 SHALL have port redirect_PC  output  PC_W  fetch restart address.
REQ-013 SHALL have port we  output  1  BTB write enable.
REQ-014 SHALL have port PC_actual  output  PC_W  BTB write PC.
REQ-015 SHALL have port NPC_actual  output  PC_W  BTB write target.
REQ-016 SHALL have port mispredict_cnt  output  16  saturating mispredict count.
REQ-017 SHALL have port drop_cnt  output  16  saturating dropped-update count.

Function
REQ-018 SHALL define mispredict = ex_valid & ex_is_branch & (ex_NPC_actual != ex_NPC_predict).
REQ-019 On mispredict, SHALL assert redirect for exactly one cycle on the next edge, with redirect_PC = ex_NPC_actual.
REQ-020 SHALL compare full PC_W bits; bits [1:0] of stored addresses are forced to 0 on enqueue.
REQ-021 On mispredict with queue not full, SHALL enqueue {ex_PC, ex_NPC_actual} at the tail on the same edge.
REQ-022 On mispredict with queue full and no drain that cycle, SHALL discard the new update and increment drop_cnt.
REQ-023 With queue full and a drain in the same cycle, SHALL accept the push (simultaneous push/pop allowed).
REQ-024 SHALL drain when queue non-empty and btb_hold=0: we=1 for one cycle with PC_actual/NPC_actual = head entry, head popped on that edge.
REQ-025 we, PC_actual, NPC_actual SHALL be registered; the first write appears one cycle after enqueue (minimum latency 1 edge enqueue, 1 edge issue).
REQ-026 SHALL issue at most one BTB write per cycle, in FIFO order; when we=0, PC_actual/NPC_actual hold their last value.
REQ-027 Non-mispredicted branches and non-branches SHALL cause no enqueue, no redirect, no count change.
REQ-028 mispredict_cnt SHALL increment on every mispredict (including dropped ones) and saturate at 0xFFFF; drop_cnt likewise saturates.
REQ-029 Read and write pointers SHALL be log2(DEPTH)+1 bits; full/empty derived from MSB/index comparison; wrap-around transparent.

Reset
REQ-030 Asserting rst SHALL immediately clear queue pointers, redirect, we, PC_actual, NPC_actual, mispredict_cnt, drop_cnt to 0, including mid-drain; queued updates are discarded.
REQ-031 Queue storage need not be reset; no entry is observable until written after reset.
REQ-032 The first edge after rst deassertion SHALL process inputs normally.

Configuration
REQ-033 Macro BTB_UPD_MERGE_EN: when defined, a mispredict whose ex_PC equals the tail entry PC (queue non-empty, tail not being popped this cycle) SHALL overwrite the tail's target instead of pushing, and never counts as a drop; when undefined, every mispredict pushes per REQ-021/022.

Structure
REQ-034 Package btb_pkg SHALL hold PC_W default, DEPTH default, and the update-entry struct {pc, npc}.
REQ-035 Queue SHALL be a sub-module btb_upd_fifo (push, pop, full, empty, head, tail-overwrite port); control, counters and redirect reside in btb_update_ctrl.

Verification
REQ-036 Mispredict ex_PC=0x0100, actual=0x0200, predict=0x0104 -> redirect=1, redirect_PC=0x0200 next cycle; we=1 with 0x0100/0x0200 one cycle later; mispredict_cnt=1.
REQ-037 Correct prediction (actual=predict=0x0104) -> no redirect, no we, counters 0.
REQ-038 btb_hold=1, 5 mispredicts with DEPTH=4 -> 4 queued, drop_cnt=1; release hold -> 4 consecutive we pulses in order.
REQ-039 Full queue, hold=0, mispredict same cycle as drain -> push accepted, drop_cnt unchanged.
REQ-040 Two back-to-back mispredicts at PC 0x0300 with hold=1 -> with BTB_UPD_MERGE_EN one entry holding the second target; without it, two entries.
REQ-041 rst asserted mid-drain of 3 entries -> we drops to 0 immediately; no further writes after release.
